// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the fetch stage: instruction width, the NOP word
// injected on a redirect, the default reset PC and the fetch FSM state type.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int                     INSTR_WIDTH      = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0]            DEFAULT_RESET_PC = 32'h0000_0000;

  // FILL: no fetch in flight (after reset or redirect).
  // RUN : one fetch in flight; its data arrives on the next edge.
  typedef enum logic {
    FETCH_FILL = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Holds the byte address of the next word to issue to instruction memory.
// Next value: word-aligned redirect target, else pc+4 when advancing, else hold.
//
// Ports
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-high reset (pc = RESET_PC)
//   advance_i         in   step pc by 4 on this edge
//   redirect_i        in   load redirect target on this edge (wins over advance)
//   redirect_target_i in   byte target; bits [1:0] are ignored
//   pc_o              out  current pc
// -----------------------------------------------------------------------------
module program_counter
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Byte-offset bits of the target are dropped: fetches are always word aligned.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target_i[1:0];

  always_comb begin
    // NOTE: default assignment first so no path leaves pc_d unassigned (no latch).
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_target_i[31:2], 2'b00};
    end else if (advance_i) begin
      pc_d = pc_q + 32'd4;  // wraps modulo 2^32
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage in front of a synchronous-read instruction memory (data valid one
// cycle after its address). Keeps one fetch in flight (pend_pc) and registers
// the returned word into the IF/ID outputs, one instruction per cycle.
// Stall freezes everything; a redirect flushes the in-flight fetch, injects a
// NOP bubble and restarts at the target (two-bubble penalty).
//
// Ports
//   clk                  in   clock, rising edge
//   rst                  in   asynchronous active-high reset
//   Instruction_Address  out  word address to instruction memory (combinational)
//   Instruction          in   memory read data for the previous cycle's address
//   stall                in   decode back-pressure: hold IF/ID and fetch state
//   redirect_valid       in   taken branch/jump strobe (overrides stall)
//   redirect_target      in   branch/jump byte target
//   if_id_instruction    out  registered fetched instruction
//   if_id_pc             out  byte address of if_id_instruction
//   if_id_pc_plus4       out  if_id_pc + 4
//   if_id_valid          out  IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  Instruction_Address,
  input  logic [INSTR_WIDTH-1:0] Instruction,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic [INSTR_WIDTH-1:0] if_id_instruction,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_pc_plus4,
  output logic                   if_id_valid
);

  logic [31:0]            pc;
  logic [31:0]            pend_pc_q;
  logic                   pend_valid_q;
  fetch_state_e           state_q;
  logic [INSTR_WIDTH-1:0] if_id_instruction_q;
  logic [31:0]            if_id_pc_q;
  logic [31:0]            if_id_pc_plus4_q;
  logic                   if_id_valid_q;

  // pc steps on every unstalled edge in both FILL and RUN; redirect overrides.
  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk               (clk),
    .rst               (rst),
    .advance_i         (!stall),
    .redirect_i        (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_o              (pc)
  );

  // While stalled, keep re-reading the in-flight word so its data is still on
  // Instruction when the stall releases.
  assign Instruction_Address = (stall && pend_valid_q) ? pend_pc_q[ADDR_WIDTH+1:2]
                                                       : pc[ADDR_WIDTH+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= FETCH_FILL;
      pend_pc_q           <= RESET_PC;
      pend_valid_q        <= 1'b0;
      if_id_instruction_q <= '0;
      if_id_pc_q          <= '0;
      if_id_pc_plus4_q    <= '0;
      if_id_valid_q       <= 1'b0;
    end else if (redirect_valid) begin
      // Flush: the in-flight word is on the wrong path. IF/ID pc fields hold.
      state_q             <= FETCH_FILL;
      pend_valid_q        <= 1'b0;
      if_id_instruction_q <= NOP_INSTR;
      if_id_valid_q       <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        FETCH_FILL: begin
          pend_pc_q     <= pc;
          pend_valid_q  <= 1'b1;
          if_id_valid_q <= 1'b0;
          state_q       <= FETCH_RUN;
        end
        FETCH_RUN: begin
          if_id_instruction_q <= Instruction;
          if_id_pc_q          <= pend_pc_q;
          if_id_pc_plus4_q    <= pend_pc_q + 32'd4;
          if_id_valid_q       <= 1'b1;
          pend_pc_q           <= pc;
        end
      endcase
    end
  end

  assign if_id_instruction = if_id_instruction_q;
  assign if_id_pc          = if_id_pc_q;
  assign if_id_pc_plus4    = if_id_pc_plus4_q;
  assign if_id_valid       = if_id_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Two fetch units (RESET_PC 0 and 0x7C) share clock and control inputs, each
// with its own 32-word memory holding 0x1000_0000+k at word k. A stream-level
// model predicts the IF/ID outputs from the fetch rules; directed literal
// checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int          AW    = 5;
  localparam logic [31:0] RPC0  = 32'h0000_0000;
  localparam logic [31:0] RPC1  = 32'h0000_007C;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [AW-1:0] addr    [2];
  logic [31:0]   instr   [2];
  logic [31:0]   o_instr [2];
  logic [31:0]   o_pc    [2];
  logic [31:0]   o_pc4   [2];
  logic          o_valid [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RPC0), .ADDR_WIDTH(AW)) dut0 (
    .clk                 (clk),
    .rst                 (rst),
    .Instruction_Address (addr[0]),
    .Instruction         (instr[0]),
    .stall               (stall),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .if_id_instruction   (o_instr[0]),
    .if_id_pc            (o_pc[0]),
    .if_id_pc_plus4      (o_pc4[0]),
    .if_id_valid         (o_valid[0])
  );

  instruction_fetch_unit #(.RESET_PC(RPC1), .ADDR_WIDTH(AW)) dut1 (
    .clk                 (clk),
    .rst                 (rst),
    .Instruction_Address (addr[1]),
    .Instruction         (instr[1]),
    .stall               (stall),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .if_id_instruction   (o_instr[1]),
    .if_id_pc            (o_pc[1]),
    .if_id_pc_plus4      (o_pc4[1]),
    .if_id_valid         (o_valid[1])
  );

  // Synchronous-read instruction memories: word k holds 0x1000_0000 + k.
  always @(posedge clk) begin
    instr[0] <= 32'h1000_0000 + 32'(addr[0]);
    instr[1] <= 32'h1000_0000 + 32'(addr[1]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stream model: after reset/redirect one unstalled edge passes with nothing
  // delivered, then every unstalled edge delivers the word at m_next and steps
  // it by 4. Redirect drops the stream and shows a NOP with valid low.
  // ---------------------------------------------------------------------------
  logic [31:0] m_next  [2];
  logic        m_fill  [2];
  logic        m_valid [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_pc4   [2];

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return 32'h1000_0000 + ((byte_addr / 4) % 32);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_next[d]  <= (d == 0) ? RPC0 : RPC1;
        m_fill[d]  <= 1'b1;
        m_valid[d] <= 1'b0;
        m_instr[d] <= 32'h0;
        m_pc[d]    <= 32'h0;
        m_pc4[d]   <= 32'h0;
      end else if (redirect_valid) begin
        m_next[d]  <= redirect_target & ~32'h3;
        m_fill[d]  <= 1'b1;
        m_valid[d] <= 1'b0;
        m_instr[d] <= 32'h0;
      end else if (!stall) begin
        if (m_fill[d]) begin
          m_fill[d]  <= 1'b0;
          m_valid[d] <= 1'b0;
        end else begin
          m_valid[d] <= 1'b1;
          m_instr[d] <= word_at(m_next[d]);
          m_pc[d]    <= m_next[d];
          m_pc4[d]   <= m_next[d] + 32'd4;
          m_next[d]  <= m_next[d] + 32'd4;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d valid", d), 32'(o_valid[d]), 32'(m_valid[d]));
      check($sformatf("d%0d instr", d), o_instr[d], m_instr[d]);
      check($sformatf("d%0d pc", d),    o_pc[d],    m_pc[d]);
      check($sformatf("d%0d pc4", d),   o_pc4[d],   m_pc4[d]);
    end
  end

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] target;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_007E};  // -> 0x7C
    vecs[3]  = '{1'b1, 1'b0, 32'h0};          // stall during fill
    vecs[4]  = '{1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0};          // word 31 arrives
    vecs[6]  = '{1'b0, 1'b0, 32'h0};          // 0x80 wraps to word 0
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0010};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0020};  // back-to-back redirect
    vecs[9]  = '{1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0};

    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    // Reset state.
    #3;
    check("rst addr0",  32'(addr[0]), 32'd0);
    check("rst addr1",  32'(addr[1]), 32'd31);
    check("rst valid0", 32'(o_valid[0]), 32'd0);
    check("rst instr0", o_instr[0], 32'h0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two edges to the first valid instruction.
    @(negedge clk);
    check("fill valid0", 32'(o_valid[0]), 32'd0);
    @(negedge clk);
    check("first valid0", 32'(o_valid[0]), 32'd1);
    check("first instr0", o_instr[0], 32'h1000_0000);
    check("first pc0",    o_pc[0],    32'h0);
    check("first instr1", o_instr[1], 32'h1000_001F);
    check("first pc1",    o_pc[1],    32'h0000_007C);
    @(negedge clk);
    check("second instr0", o_instr[0], 32'h1000_0001);
    check("second pc0",    o_pc[0],    32'h4);
    check("wrap instr1",   o_instr[1], 32'h1000_0000);
    check("wrap pc1",      o_pc[1],    32'h0000_0080);
    check("wrap pc4_1",    o_pc4[1],   32'h0000_0084);

    // Word 3 in flight after this edge; stall three cycles.
    @(negedge clk);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall addr0", 32'(addr[0]), 32'd3);
      check("stall pc0",   o_pc[0], 32'h8);
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall instr0", o_instr[0], 32'h1000_0003);
    check("unstall pc0",    o_pc[0],    32'hC);
    @(negedge clk);
    check("next instr0", o_instr[0], 32'h1000_0004);
    check("next pc0",    o_pc[0],    32'h10);

    // Redirect to 0x42 (word 16).
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0042;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir valid0", 32'(o_valid[0]), 32'd0);
    check("redir instr0", o_instr[0], 32'h0);
    @(negedge clk);
    check("redir bubble2", 32'(o_valid[0]), 32'd0);
    @(negedge clk);
    check("redir tgt valid0", 32'(o_valid[0]), 32'd1);
    check("redir tgt pc0",    o_pc[0],    32'h40);
    check("redir tgt instr0", o_instr[0], 32'h1000_0010);

    // Redirect and stall on the same edge: redirect wins.
    redirect_valid  = 1'b1;
    stall           = 1'b1;
    redirect_target = 32'h0000_0009;
    @(negedge clk);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check("rs valid0", 32'(o_valid[0]), 32'd0);
    check("rs instr0", o_instr[0], 32'h0);
    repeat (2) @(negedge clk);
    check("rs tgt pc0",    o_pc[0],    32'h8);
    check("rs tgt instr0", o_instr[0], 32'h1000_0002);

    // Mixed stall/redirect vectors, checked by the model.
    for (int i = 0; i < NVEC; i++) begin
      stall           = vecs[i].stall;
      redirect_valid  = vecs[i].redir;
      redirect_target = vecs[i].target;
      @(negedge clk);
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-clock while stalled.
    stall = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async valid0", 32'(o_valid[0]), 32'd0);
    check("async instr0", o_instr[0], 32'h0);
    check("async pc0",    o_pc[0],    32'h0);
    check("async pc4_0",  o_pc4[0],   32'h0);
    check("async addr1",  32'(addr[1]), 32'd31);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("restart fill0", 32'(o_valid[0]), 32'd0);
    @(negedge clk);
    check("restart valid0", 32'(o_valid[0]), 32'd1);
    check("restart instr0", o_instr[0], 32'h1000_0000);
    check("restart pc0",    o_pc[0],    32'h0);
    repeat (3) @(negedge clk);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5: word-address width of the instruction memory.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Port Instruction_Address  output  ADDR_WIDTH  SHALL be the word address driven to the instruction memory.
REQ-006 Port Instruction  input  32  SHALL be the memory read data, valid one cycle after its address.
REQ-007 Port stall  input  1  SHALL be the decode back-pressure; 1 means hold the IF/ID outputs.
REQ-008 Port redirect_valid  input  1  SHALL be the branch/jump taken strobe.
REQ-009 Port redirect_target  input  32  SHALL be the branch/jump byte target, sampled when redirect_valid=1.
REQ-010 Port if_id_instruction  output  32  SHALL be the registered fetched instruction.
REQ-011 Port if_id_pc  output  32  SHALL be the byte address of if_id_instruction.
REQ-012 Port if_id_pc_plus4  output  32  SHALL be if_id_pc+4, mod 2^32.
REQ-013 Port if_id_valid  output  1  SHALL be 1 when the IF/ID outputs hold a real instruction.

Function
REQ-014 Internal state: pc (next address to issue); pend_pc and pend_valid (fetch in flight); FSM {FILL, RUN}.
REQ-015 Instruction_Address SHALL be combinational: pend_pc[ADDR_WIDTH+1:2] when stall=1 and pend_valid=1, else pc[ADDR_WIDTH+1:2].
  - Under stall the memory keeps re-reading the in-flight word.
REQ-016 FILL: pend_valid=0. On a non-stall, non-redirect edge: pend_pc<=pc, pend_valid<=1, pc<=pc+4, go to RUN, if_id_valid<=0.
REQ-017 RUN, stall=0, redirect_valid=0, each edge:
  - if_id_instruction<=Instruction; if_id_pc<=pend_pc; if_id_pc_plus4<=pend_pc+4; if_id_valid<=1
  - pend_pc<=pc; pc<=pc+4
REQ-018 stall=1 with redirect_valid=0 SHALL hold pc, pend_pc, pend_valid, FSM state and all if_id_* registers unchanged.
REQ-019 redirect_valid=1 SHALL override stall and, on that edge:
  - pc<={redirect_target[31:2],2'b00}, ignoring target bits [1:0]
  - pend_valid<=0, FSM<=FILL, if_id_valid<=0
  - if_id_instruction<=32'h0000_0000 (NOP)
  - if_id_pc and if_id_pc_plus4 held
REQ-020 Redirect penalty SHALL be exactly 2 bubbles: the target instruction appears with if_id_valid=1 on the second edge after the redirect edge, absent further stall or redirect.
REQ-021 pc+4 SHALL wrap modulo 2^32; Instruction_Address SHALL wrap naturally at 2^ADDR_WIDTH words.
REQ-022 Steady-state throughput SHALL be one instruction per cycle with no stall or redirect.

Reset
REQ-023 While rst=1, immediately and independent of clk:
  - pc=RESET_PC; pend_pc=RESET_PC; pend_valid=0; FSM=FILL
  - if_id_instruction=0; if_id_pc=0; if_id_pc_plus4=0; if_id_valid=0
REQ-024 During reset Instruction_Address SHALL equal RESET_PC[ADDR_WIDTH+1:2].
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard the in-flight fetch; no instruction issued before reset SHALL reach IF/ID afterwards.

Structure
REQ-026 Shared package mips_pkg SHALL hold INSTR_WIDTH=32, NOP_INSTR=32'h0000_0000, the default RESET_PC and the fetch FSM state type.
REQ-027 pc and its +4/redirect/hold next-value logic SHALL be one sub-module, program_counter; the pending register, FSM and IF/ID register stay in the top module.

Verification
REQ-028 Reset release, memory word k = 32'h1000_0000+k, no stall:
  - if_id_valid rises 2 edges after release with instruction 32'h1000_0000, if_id_pc=0
  - then consecutive words, pc step 4
REQ-029 stall=1 for 3 cycles while instruction word 3 is in flight:
  - if_id_* frozen; Instruction_Address=3 throughout
  - after release, word 3 then word 4, none lost or duplicated
REQ-030 redirect_valid=1, redirect_target=32'h0000_0042:
  - next edge: if_id_valid=0, instruction=0
  - second edge after: if_id_pc=32'h40, word 16
REQ-031 redirect_valid=1 and stall=1 on the same edge: redirect wins and the target is fetched as in REQ-030.
REQ-032 RESET_PC=32'h0000_007C: fetch sequence is word 31 then word 0 (address wrap), with if_id_pc=32'h7C then 32'h80.
REQ-033 rst pulse mid-clock during RUN: outputs zero asynchronously; after release the fetch restarts at RESET_PC with no stale instruction valid.
